// File: rtl/risc_processor_if.sv
// External I/O bundle of the RISC core: four input ports sampled by IN
// and four registered output ports written by OUT.
interface risc_processor_if;
   logic [7:0] InpExtWorld1;
   logic [7:0] InpExtWorld2;
   logic [7:0] InpExtWorld3;
   logic [7:0] InpExtWorld4;
   logic [7:0] OutExtWorld1;
   logic [7:0] OutExtWorld2;
   logic [7:0] OutExtWorld3;
   logic [7:0] OutExtWorld4;

   modport master (
      output InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4,
      input  OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4
   );

   modport slave (
      input  InpExtWorld1, InpExtWorld2, InpExtWorld3, InpExtWorld4,
      output OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4
   );
endinterface

// File: rtl/risc_processor.sv
// Single-cycle 8-bit RISC core running a fixed program from a 256x16 ROM.
// Fetch, decode, register read and ALU are combinational from the current PC.
module risc_processor (
   input  logic             clk,
   input  logic             Reset,
   risc_processor_if.slave  io
);

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_XOR  = 4'h6,
      OP_IN   = 4'h7,
      OP_OUT  = 4'h8,
      OP_JMP  = 4'h9,
      OP_BZ   = 4'hA,
      OP_SHL  = 4'hB,
      OP_SHR  = 4'hC,
      OP_ADDI = 4'hD,
      OP_RSVD = 4'hE,
      OP_HALT = 4'hF
   } opcode_t;

   logic [7:0]  r_pc;
   logic [7:0]  r_regs [8];
   logic [7:0]  r_out  [4];
   logic        r_halt;

   logic [15:0] w_instr;
   opcode_t     w_op;
   logic [2:0]  w_rd;
   logic [2:0]  w_rs;
   logic [2:0]  w_rt;
   logic [7:0]  w_imm;
   logic [1:0]  w_port;
   logic [7:0]  w_rd_val;
   logic [7:0]  w_rs_val;
   logic [7:0]  w_rt_val;
   logic [7:0]  w_inp [4];
   logic [7:0]  w_result;
   logic        w_wr_en;
   logic        w_out_en;
   logic [7:0]  w_pc_next;
   logic        w_exec;

   // Program ROM; unlisted addresses decode as NOP.
   always_comb begin
      w_instr = 16'h0000;
      case (r_pc)
         8'd0:    w_instr = 16'h7200;
         8'd1:    w_instr = 16'h7401;
         8'd2:    w_instr = 16'h2650;
         8'd3:    w_instr = 16'h8600;
         8'd4:    w_instr = 16'h3850;
         8'd5:    w_instr = 16'h8801;
         8'd6:    w_instr = 16'h7A02;
         8'd7:    w_instr = 16'h7C03;
         8'd8:    w_instr = 16'h6F70;
         8'd9:    w_instr = 16'h8E02;
         8'd10:   w_instr = 16'h4F70;
         8'd11:   w_instr = 16'h8E03;
         8'd12:   w_instr = 16'h9000;
         default: w_instr = 16'h0000;
      endcase
   end

   assign w_op     = opcode_t'(w_instr[15:12]);
   assign w_rd     = w_instr[11:9];
   assign w_rs     = w_instr[8:6];
   assign w_rt     = w_instr[5:3];
   assign w_imm    = w_instr[7:0];
   assign w_port   = w_imm[1:0];
   assign w_rd_val = r_regs[w_rd];
   assign w_rs_val = r_regs[w_rs];
   assign w_rt_val = r_regs[w_rt];
   assign w_exec   = ~r_halt;

   assign w_inp[0] = io.InpExtWorld1;
   assign w_inp[1] = io.InpExtWorld2;
   assign w_inp[2] = io.InpExtWorld3;
   assign w_inp[3] = io.InpExtWorld4;

   always_comb begin
      w_result  = 8'h00;
      w_wr_en   = 1'b0;
      w_out_en  = 1'b0;
      w_pc_next = r_pc + 8'd1;
      case (w_op)
         OP_LDI:  begin w_result = w_imm;               w_wr_en = 1'b1; end
         OP_ADD:  begin w_result = w_rs_val + w_rt_val; w_wr_en = 1'b1; end
         OP_SUB:  begin w_result = w_rs_val - w_rt_val; w_wr_en = 1'b1; end
         OP_AND:  begin w_result = w_rs_val & w_rt_val; w_wr_en = 1'b1; end
         OP_OR:   begin w_result = w_rs_val | w_rt_val; w_wr_en = 1'b1; end
         OP_XOR:  begin w_result = w_rs_val ^ w_rt_val; w_wr_en = 1'b1; end
         OP_IN:   begin w_result = w_inp[w_port];       w_wr_en = 1'b1; end
         OP_OUT:  w_out_en = 1'b1;
         OP_JMP:  w_pc_next = w_imm;
         OP_BZ:   if (w_rd_val == 8'h00) w_pc_next = w_imm;
         OP_SHL:  begin w_result = {w_rs_val[6:0], 1'b0}; w_wr_en = 1'b1; end
         OP_SHR:  begin w_result = {1'b0, w_rs_val[7:1]}; w_wr_en = 1'b1; end
         OP_ADDI: begin w_result = w_rd_val + w_imm;      w_wr_en = 1'b1; end
         OP_HALT: w_pc_next = r_pc;
         default: ;
      endcase
   end

   // PC, register file and halt flag; a halted core freezes all state.
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_pc   <= 8'h00;
         r_halt <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= 8'h00;
         end
      end else if (w_exec) begin
         r_pc <= w_pc_next;
         if (w_wr_en) begin
            r_regs[w_rd] <= w_result;
         end
         if (w_op == OP_HALT) begin
            r_halt <= 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_out_port
         always_ff @(posedge clk) begin
            if (Reset) begin
               r_out[gi] <= 8'h00;
            end else if (w_exec && w_out_en && (w_port == gi[1:0])) begin
               r_out[gi] <= w_rd_val;
            end
         end
      end
   endgenerate

   assign io.OutExtWorld1 = r_out[0];
   assign io.OutExtWorld2 = r_out[1];
   assign io.OutExtWorld3 = r_out[2];
   assign io.OutExtWorld4 = r_out[3];

endmodule

// File: tb/tb_risc_processor.sv
// Directed bench for risc_processor: edge-accurate output schedule, wrap
// arithmetic, loop behaviour, mid-run reset and an all-zero idle run.
module tb_risc_processor;

   logic clk;
   logic Reset;
   int   n_checks;
   int   n_errors;

   risc_processor_if io ();

   risc_processor dut (
      .clk   (clk),
      .Reset (Reset),
      .io    (io.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_inputs(input logic [7:0] a, b, c, d);
      io.InpExtWorld1 = a;
      io.InpExtWorld2 = b;
      io.InpExtWorld3 = c;
      io.InpExtWorld4 = d;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      step(2);
      Reset = 1'b0;
   endtask

   function automatic logic [31:0] outs();
      return {io.OutExtWorld1, io.OutExtWorld2, io.OutExtWorld3, io.OutExtWorld4};
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      Reset    = 1'b1;
      set_inputs(8'h55, 8'h55, 8'h55, 8'h55);

      // Reset with all inputs 0x55
      do_reset();
      check("reset_outs", outs(), 32'h0000_0000);
      check("reset_pc", {24'h0, dut.r_pc}, 32'h0);
      step(12);
      check("r55_after12", outs(), 32'hAA00_0055);

      // Basic schedule
      set_inputs(8'd10, 8'd3, 8'hF0, 8'h3C);
      do_reset();
      step(3);
      check("basic_out1_e3", {24'h0, io.OutExtWorld1}, 32'd0);
      step(1);
      check("basic_out1_e4", {24'h0, io.OutExtWorld1}, 32'd13);
      step(1);
      check("basic_out2_e5", {24'h0, io.OutExtWorld2}, 32'd0);
      step(1);
      check("basic_out2_e6", {24'h0, io.OutExtWorld2}, 32'd7);
      step(3);
      check("basic_out3_e9", {24'h0, io.OutExtWorld3}, 32'd0);
      step(1);
      check("basic_out3_e10", {24'h0, io.OutExtWorld3}, 32'hCC);
      step(2);
      check("basic_out4_e12", {24'h0, io.OutExtWorld4}, 32'h30);
      step(1);
      check("basic_pc_e13", {24'h0, dut.r_pc}, 32'd0);

      // Loop with changed inputs before edge 14
      set_inputs(8'd1, 8'd1, 8'hF0, 8'h3C);
      step(3);
      check("loop_out1_hold_e16", {24'h0, io.OutExtWorld1}, 32'd13);
      step(1);
      check("loop_out1_e17", {24'h0, io.OutExtWorld1}, 32'd2);
      step(1);
      check("loop_out2_hold_e18", {24'h0, io.OutExtWorld2}, 32'd7);
      step(1);
      check("loop_out2_e19", {24'h0, io.OutExtWorld2}, 32'd0);
      check("loop_out34_hold_e19", {16'h0, io.OutExtWorld3, io.OutExtWorld4}, 32'hCC30);

      // Wrap arithmetic
      set_inputs(8'd200, 8'd100, 8'h00, 8'h00);
      do_reset();
      step(6);
      check("wrap_add", {24'h0, io.OutExtWorld1}, 32'h2C);
      check("wrap_sub_pos", {24'h0, io.OutExtWorld2}, 32'h64);
      set_inputs(8'd3, 8'd10, 8'h00, 8'h00);
      do_reset();
      step(6);
      check("wrap_add_small", {24'h0, io.OutExtWorld1}, 32'd13);
      check("wrap_sub_neg", {24'h0, io.OutExtWorld2}, 32'hF9);

      // Mid-run reset on edge 8
      set_inputs(8'd20, 8'd5, 8'h0F, 8'hFF);
      do_reset();
      step(7);
      check("mid_pre_reset", outs(), {8'd25, 8'd15, 8'h00, 8'h00});
      Reset = 1'b1;
      step(1);
      check("mid_reset_outs", outs(), 32'h0);
      check("mid_reset_pc", {24'h0, dut.r_pc}, 32'h0);
      Reset = 1'b0;
      step(3);
      check("mid_restart_e3", {24'h0, io.OutExtWorld1}, 32'd0);
      step(1);
      check("mid_restart_e4", {24'h0, io.OutExtWorld1}, 32'd25);
      step(8);
      check("mid_restart_e12", outs(), {8'd25, 8'd15, 8'hF0, 8'h0F});

      // Idle: all-zero inputs for 50 cycles
      set_inputs(8'h00, 8'h00, 8'h00, 8'h00);
      do_reset();
      for (int k = 1; k <= 50; k++) begin
         step(1);
         check($sformatf("idle_outs_e%0d", k), outs(), 32'h0);
         check($sformatf("idle_pc_e%0d", k), {24'h0, dut.r_pc}, k % 13);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
